// File: rtl/afifo_rd_port.sv
`default_nettype none
// ============================================================================
// Module   : afifo_rd_port
// Purpose  : Read-side controller of the asynchronous FIFO (clk2 domain).
//            Synchronizes the Gray write pointer, keeps the binary/Gray read
//            pointer, generates a registered empty flag and the storage read
//            address, and presents popped words through a registered
//            valid/ready output stage.
// Ports    : clk2, rst_n      - read clock, async active-low reset
//            wptr_gray        - Gray write pointer from the clk1 domain
//            rdata_mem        - combinational storage read data at raddr
//            out_ready        - downstream accepts out_data this cycle
//            rptr_gray        - registered Gray read pointer to the writer
//            raddr            - storage read address
//            rempty           - registered FIFO-empty flag
//            out_valid/out_data - popped word output stage
//            rlevel           - occupancy seen from the read side
// Options  : AFIFO_SYNC3_EN - three-flop write-pointer synchronizer
// Revision : 1.0 - initial release
// ============================================================================
module afifo_rd_port #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic [ASIZE:0]   wptr_gray,
  input  logic [DSIZE-1:0] rdata_mem,
  input  logic             out_ready,
  output logic [ASIZE:0]   rptr_gray,
  output logic [ASIZE-1:0] raddr,
  output logic             rempty,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic [ASIZE:0]   rlevel
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state;
  logic [ASIZE:0] rbin;
  logic [ASIZE:0] rbin_next;
  logic [ASIZE:0] rgray_next;
  logic [ASIZE:0] wq1;
  logic [ASIZE:0] wq2;
  logic [ASIZE:0] wsync;   // last synchronizer stage, the only use of the write pointer
  logic           pop;

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

`ifdef AFIFO_SYNC3_EN
  logic [ASIZE:0] wq3;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      wq1 <= '0;
      wq2 <= '0;
      wq3 <= '0;
    end else begin
      wq1 <= wptr_gray;
      wq2 <= wq1;
      wq3 <= wq2;
    end
  end

  assign wsync = wq3;
`else
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wptr_gray;
      wq2 <= wq1;
    end
  end

  assign wsync = wq2;
`endif

  // A word leaves storage whenever there is one and the output register is
  // free or being drained in the same cycle.
  assign pop        = ~rempty & (~out_valid | out_ready);
  assign rbin_next  = rbin + {{ASIZE{1'b0}}, pop};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  assign raddr     = rbin[ASIZE-1:0];
  assign out_valid = (state == HOLD);
  assign rlevel    = gray2bin(wsync) - rbin;

  // Pointer, empty flag and output stage share one register block; the
  // state register itself is the out_valid flag.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      rempty    <= 1'b1;
      state     <= IDLE;
      out_data  <= '0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rgray_next;
      // Compare against the next pointer so the flag is valid on the same
      // edge that consumes the last word.
      rempty    <= (rgray_next == wsync);
      case (state)
        IDLE: begin
          if (pop) begin
            out_data <= rdata_mem;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (pop) begin
              out_data <= rdata_mem;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_afifo_rd_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_afifo_rd_port
// Purpose  : Self-checking bench for afifo_rd_port. Directed per-cycle table
//            for single-word and backpressure cases, hand sequences for
//            reset, burst/wrap and latency, plus a clk1 writer model driving
//            random traffic against an order-preserving scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_afifo_rd_port;

  localparam int DSIZE  = 8;
  localparam int ASIZE  = 4;
  localparam int NWORDS = 1000;
`ifdef AFIFO_SYNC3_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [ASIZE:0] ONE = 1;

  logic             clk1 = 1'b0;
  logic             clk2 = 1'b0;
  logic             rst_n;
  logic [ASIZE:0]   wptr_gray;
  logic [ASIZE:0]   d_wptr;
  logic [ASIZE:0]   a_wptr;
  logic [DSIZE-1:0] rdata_mem;
  logic             out_ready;
  logic [ASIZE:0]   rptr_gray;
  logic [ASIZE-1:0] raddr;
  logic             rempty;
  logic             out_valid;
  logic [DSIZE-1:0] out_data;
  logic [ASIZE:0]   rlevel;
  logic             async_mode;

  logic [DSIZE-1:0] dmem [16];
  logic [DSIZE-1:0] amem [16];

  int checks   = 0;
  int failures = 0;

  always #5 clk2 = ~clk2;
  initial begin
    #1;
    forever #3.5 clk1 = ~clk1;
  end

  assign wptr_gray = async_mode ? a_wptr : d_wptr;
  assign rdata_mem = async_mode ? amem[raddr] : dmem[raddr];

  afifo_rd_port #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk2      (clk2),
    .rst_n     (rst_n),
    .wptr_gray (wptr_gray),
    .rdata_mem (rdata_mem),
    .out_ready (out_ready),
    .rptr_gray (rptr_gray),
    .raddr     (raddr),
    .rempty    (rempty),
    .out_valid (out_valid),
    .out_data  (out_data),
    .rlevel    (rlevel)
  );

  function automatic logic [ASIZE:0] gray(input logic [ASIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    d_wptr    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk2);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- clk1 writer model (random traffic) ----------------
  logic [ASIZE:0]   a_wbin;
  logic [ASIZE:0]   rq1;
  logic [ASIZE:0]   rq2;
  logic [DSIZE-1:0] next_d;
  logic             wfull;
  int               wr_count;
  logic [DSIZE-1:0] wexp [$];

  assign wfull = (a_wptr == {~rq2[ASIZE:ASIZE-1], rq2[ASIZE-2:0]});

  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      a_wbin   <= '0;
      a_wptr   <= '0;
      rq1      <= '0;
      rq2      <= '0;
      wr_count <= 0;
      next_d   <= 8'($urandom);
    end else begin
      rq1 <= rptr_gray;
      rq2 <= rq1;
      if (async_mode && wr_count < NWORDS && !wfull && $urandom_range(0, 3) != 0) begin
        amem[a_wbin[ASIZE-1:0]] <= next_d;
        wexp.push_back(next_d);
        a_wbin   <= a_wbin + ONE;
        a_wptr   <= gray(a_wbin + ONE);
        wr_count <= wr_count + 1;
        next_d   <= 8'($urandom);
      end
    end
  end

  // ---------------- Gray read pointer: one bit per change ----------------
  logic [ASIZE:0] prev_rptr;
  logic           prev_ok = 1'b0;

  always @(negedge clk2) begin
    if (!rst_n) begin
      prev_ok <= 1'b0;
    end else begin
      if (prev_ok && rptr_gray != prev_rptr)
        check("gray_one_bit", 32'($countones(rptr_gray ^ prev_rptr)), 32'd1);
      prev_rptr <= rptr_gray;
      prev_ok   <= 1'b1;
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic             rst;
    logic [ASIZE:0]   wptr;
    logic             rdy;
    logic             empty;
    logic             valid;
    logic [DSIZE-1:0] data;
    logic [ASIZE:0]   rptr;
    logic [ASIZE:0]   lvl;
  } vec_t;

`ifndef AFIFO_SYNC3_EN
  vec_t tbl [17];
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int j;
    int e;
    logic [DSIZE-1:0] exp_d;

    async_mode = 1'b0;
    rst_n      = 1'b0;
    d_wptr     = '0;
    out_ready  = 1'b0;
    for (int i = 0; i < 16; i++) dmem[i] = 8'h00;
    for (int i = 0; i < 16; i++) amem[i] = 8'h00;
    dmem[0] = 8'hA5;
    dmem[1] = 8'hB6;
    dmem[2] = 8'hC7;

    repeat (3) @(posedge clk2);
    #1;
    check("rst_rempty", rempty, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_rptr", rptr_gray, 0);
    check("rst_raddr", raddr, 0);
    check("rst_level", rlevel, 0);
    rst_n = 1'b1;

`ifndef AFIFO_SYNC3_EN
    //          rst wptr      rdy empty valid data   rptr      lvl
    // single word: write pointer 0 -> 1 before edge 0
    tbl[0]  = '{1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, 8'h00, 5'b00000, 5'd0};
    tbl[1]  = '{1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, 8'h00, 5'b00000, 5'd1};
    tbl[2]  = '{1'b0, 5'b00001, 1'b1, 1'b0, 1'b0, 8'h00, 5'b00000, 5'd1};
    tbl[3]  = '{1'b0, 5'b00001, 1'b1, 1'b1, 1'b1, 8'hA5, 5'b00001, 5'd0};
    tbl[4]  = '{1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, 8'hA5, 5'b00001, 5'd0};
    // reset across an edge clears everything including out_data
    tbl[5]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 1'b0, 8'h00, 5'b00000, 5'd0};
    // backpressure: 3 words queued (Gray(3) = 00010), out_ready low 5 cycles
    tbl[6]  = '{1'b0, 5'b00010, 1'b0, 1'b1, 1'b0, 8'h00, 5'b00000, 5'd0};
    tbl[7]  = '{1'b0, 5'b00010, 1'b0, 1'b1, 1'b0, 8'h00, 5'b00000, 5'd3};
    tbl[8]  = '{1'b0, 5'b00010, 1'b0, 1'b0, 1'b0, 8'h00, 5'b00000, 5'd3};
    tbl[9]  = '{1'b0, 5'b00010, 1'b0, 1'b0, 1'b1, 8'hA5, 5'b00001, 5'd2};
    tbl[10] = '{1'b0, 5'b00010, 1'b0, 1'b0, 1'b1, 8'hA5, 5'b00001, 5'd2};
    tbl[11] = '{1'b0, 5'b00010, 1'b0, 1'b0, 1'b1, 8'hA5, 5'b00001, 5'd2};
    tbl[12] = '{1'b0, 5'b00010, 1'b0, 1'b0, 1'b1, 8'hA5, 5'b00001, 5'd2};
    tbl[13] = '{1'b0, 5'b00010, 1'b0, 1'b0, 1'b1, 8'hA5, 5'b00001, 5'd2};
    tbl[14] = '{1'b0, 5'b00010, 1'b1, 1'b0, 1'b1, 8'hB6, 5'b00011, 5'd1};
    tbl[15] = '{1'b0, 5'b00010, 1'b1, 1'b1, 1'b1, 8'hC7, 5'b00010, 5'd0};
    tbl[16] = '{1'b0, 5'b00010, 1'b1, 1'b1, 1'b0, 8'hC7, 5'b00010, 5'd0};

    for (int i = 0; i < 17; i++) begin
      rst_n     = ~tbl[i].rst;
      d_wptr    = tbl[i].wptr;
      out_ready = tbl[i].rdy;
      @(posedge clk2);
      #1;
      check($sformatf("vec%0d_rempty", i), rempty, tbl[i].empty);
      check($sformatf("vec%0d_valid", i), out_valid, tbl[i].valid);
      check($sformatf("vec%0d_data", i), out_data, tbl[i].data);
      check($sformatf("vec%0d_rptr", i), rptr_gray, tbl[i].rptr);
      check($sformatf("vec%0d_level", i), rlevel, tbl[i].lvl);
    end
`endif

    // ---- single-word latency: out_valid rises LAT+1 edges after the write
    do_reset();
    d_wptr    = 5'b00001;
    out_ready = 1'b1;
    e = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk2);
      #1;
      if (out_valid) break;
      e++;
    end
    check("latency_edge", e, LAT + 1);
    check("latency_data", out_data, 8'hA5);

    // ---- asynchronous reset while a word is held
    do_reset();
    d_wptr = 5'b00010;
    for (int c = 0; c < 10 && !out_valid; c++) begin
      @(posedge clk2);
      #1;
    end
    check("mid_pre_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_rempty", rempty, 1);
    check("mid_rst_rptr", rptr_gray, 0);
    check("mid_rst_level", rlevel, 0);
    check("mid_rst_data", out_data, 0);
    d_wptr = '0;
    @(posedge clk2);
    #1;
    rst_n = 1'b1;

    // ---- burst of 16 (full FIFO) then 20 more through the wrap
    do_reset();
    for (int i = 0; i < 16; i++) dmem[i] = 8'(8'h40 + i);
    d_wptr    = 5'b11000;
    out_ready = 1'b1;
    repeat (LAT) @(posedge clk2);
    #1;
    check("burst_level_full", rlevel, 16);
    check("burst_still_empty", rempty, 1);
    for (int c = 0; c < 8 && !out_valid; c++) begin
      @(posedge clk2);
      #1;
    end
    for (int k = 0; k < 16; k++) begin
      check("burst_valid", out_valid, 1);
      check("burst_data", out_data, 8'h40 + k);
      check("burst_raddr", raddr, (k + 1) % 16);
      @(posedge clk2);
      #1;
    end
    check("burst_end_valid", out_valid, 0);
    check("burst_end_rptr", rptr_gray, 5'b11000);
    check("burst_end_rempty", rempty, 1);

    j = 0;
    n = 0;
    for (int c = 0; c < 80 && n < 20; c++) begin
      if (j < 20) begin
        dmem[(16 + j) % 16] = 8'(8'h80 + j);
        d_wptr = gray(5'(16 + j + 1));
        j++;
      end
      @(posedge clk2);
      #1;
      if (out_valid) begin
        check("burst2_data", out_data, 8'h80 + n);
        n++;
      end
    end
    check("burst2_count", n, 20);
    check("burst2_rptr", rptr_gray, 5'b00110);
    check("burst2_raddr", raddr, 4);

    // ---- random traffic from the clk1 writer model
    rst_n      = 1'b0;
    async_mode = 1'b1;
    do_reset();
    n = 0;
    for (int c = 0; c < 20000 && n < NWORDS; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (wexp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL async_underflow: got %0h expected no word", out_data);
        end else begin
          exp_d = wexp.pop_front();
          check("async_data", out_data, exp_d);
        end
        n++;
      end
      @(posedge clk2);
      #1;
    end
    check("async_count", n, NWORDS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/afifo_rd_port.md
# afifo_rd_port

Read-side controller of the team's asynchronous FIFO, living entirely in the clk2 domain. It synchronizes the Gray-coded write pointer from the clk1 writer, generates the empty flag and the read address for the dual-port storage array, and presents popped words through a registered valid/ready output stage. It pairs with the existing clk1 write side and feeds the clk2 result sequencer that drives `out_valid`/`out`.

## Interface

Parameters:
- `DSIZE`, default 8, data word width.
- `ASIZE`, default 4, address width; depth = 2^ASIZE = 16 entries.

Ports:
- `clk2`: input, 1 bit, read clock.
- `rst_n`: input, 1 bit. Reset is rst_n, asynchronous, active-low; the clock is clk2.
- `wptr_gray`: input, ASIZE+1 bits, write pointer in Gray code, from the clk1 domain. Treated as asynchronous.
- `rdata_mem`: input, DSIZE bits, storage array read data. This is a combinational read of `raddr`.
- `out_ready`: input, 1 bit, downstream accepts `out_data` this cycle.
- `rptr_gray`: output, ASIZE+1 bits, registered read pointer in Gray code, sent to the write side.
- `raddr`: output, ASIZE bits, equal to `rbin[ASIZE-1:0]`.
- `rempty`: output, 1 bit, registered FIFO-empty flag.
- `out_valid`: output, 1 bit, `out_data` holds a popped word.
- `out_data`: output, DSIZE bits, popped word.
- `rlevel`: output, ASIZE+1 bits, occupancy as seen from the read side. Does not include the word held in the output register.

## Operation

- **Synchronizer.** `wptr_gray` passes through a 2-flop chain (`wq1` then `wq2`), reset to 0. `wq2` is the only point where the write pointer is used.
- **Read pointer.** `rbin` is an (ASIZE+1)-bit binary register. `rptr_gray` is a register.
  - `pop = ~rempty & (~out_valid | out_ready)`.
  - `rbin_next = rbin + pop`, wrapping modulo 2^(ASIZE+1).
  - `rgray_next = (rbin_next >> 1) ^ rbin_next`.
  - Each clk2 edge: `rbin <= rbin_next`, `rptr_gray <= rgray_next`.
- **Empty.** `rempty <= (rgray_next == wq2)`. The flag is pessimistic: it may stay 1 for up to the sync latency after a write. It is never deasserted falsely.
- **Output stage FSM.** Two states, encoded by `out_valid`:
  - **IDLE** (`out_valid` = 0): if `pop`, load `out_data <= rdata_mem` and go to HOLD. Otherwise stay.
  - **HOLD** (`out_valid` = 1):
    - `out_ready` & `pop`: load the next word, stay in HOLD (back-to-back).
    - `out_ready` & ~`pop`: go to IDLE. `out_data` keeps its last value.
    - ~`out_ready`: hold `out_data` stable and do not pop.
- **Level.** `rlevel = gray2bin(wq2) - rbin`, taken modulo 2^(ASIZE+1). Its range is 0..2^ASIZE.
- **Boundaries.**
  - Wrap-around: the MSB of the pointer toggles every 2^ASIZE pops, and `raddr` wraps 15 to 0.
  - Empty with a simultaneous write: the new data is not visible until `wq2` updates.
  - A full FIFO (`rlevel` = 16) is legal. Pops proceed normally.
  - `out_ready` while IDLE is ignored.
- **Reset mid-operation.** Asynchronously clear all registers: `rbin`, `rptr_gray`, `wq1`, `wq2`, `out_data` to 0, `out_valid` to 0, `rempty` to 1. The writer must be reset by the same `rst_n`.

## Timing

- **Reset values:** `rptr_gray` = 0, `raddr` = 0, `rempty` = 1, `out_valid` = 0, `out_data` = 0, `rlevel` = 0.
- **Write visibility:** a `wptr_gray` change sampled at clk2 edge n reaches `wq2` at edge n+1. `rempty` falls at edge n+2, and `out_valid` rises at edge n+3.
- **Throughput:** one word per clk2 cycle while `out_ready` = 1 and the FIFO is non-empty.
- **Read-pointer export:** `rptr_gray` changes on the same edge that loads `out_data`. The Gray code changes exactly one bit per pop.

## Configuration

- `AFIFO_SYNC3_EN` defined:
  - The synchronizer has three flops (`wq1`, `wq2`, `wq3`), and `wq3` replaces `wq2` in the empty and level logic.
  - Write-to-`out_valid` latency grows by one cycle, to n+4.
- Not defined: two-flop synchronizer as described above.

## Test plan

- **Reset:** assert `rst_n` = 0 mid-stream -> immediately `out_valid` = 0, `rempty` = 1, `rptr_gray` = 0, `rlevel` = 0.
- **Single word:** `rdata_mem` = 8'hA5, `wptr_gray` moves 0 to 1 at edge 0, `out_ready` = 1 -> `rempty` = 0 at edge 2; `out_valid` = 1 with `out_data` = 8'hA5 at edge 3; `rptr_gray` = 1; `out_valid` = 0 at edge 4.
- **Burst and wrap:** the writer fills 16 words (`wptr_gray` = Gray(16) = 5'b11000) -> `rlevel` = 16; 16 consecutive `out_valid` cycles; `raddr` sequence 0..15; final `rptr_gray` = 5'b11000; `rempty` = 1. A second burst of 20 words continues through `raddr` 0..3 with no lost word.
- **Backpressure:** 3 words queued, `out_ready` = 0 for 5 cycles -> `out_data` stable, `rptr_gray` frozen at Gray(1), `rlevel` = 2. Releasing `out_ready` delivers the remaining 2 words on consecutive cycles.
- **Asynchronous ratio:** clk1 = 7 ns, clk2 = 10 ns, 1000 random words through the paired writer -> order-preserving scoreboard match. `rptr_gray` changes exactly one bit per change.
- **`AFIFO_SYNC3_EN`:** repeat the single-word case -> `out_valid` rises at edge 4 instead of 3.
